// File: rtl/spi_reg_bridge_pkg.sv
// Shared definitions for the SPI register bridge: FSM encoding, command byte
// field positions and the pointer-advance helper.
package spi_reg_pkg;

   localparam int CMD_RW_BIT = 7;
   localparam int ADDR_MSB   = 6;
   localparam int ADDR_W     = ADDR_MSB + 1;

   localparam logic [2:0] ST_IDLE_ENC = 3'd0;
   localparam logic [2:0] ST_CMD_ENC  = 3'd1;
   localparam logic [2:0] ST_WR_ENC   = 3'd2;
   localparam logic [2:0] ST_RD_ENC   = 3'd3;
   localparam logic [2:0] ST_SKIP_ENC = 3'd4;

   typedef enum logic [2:0] {
      ST_IDLE = ST_IDLE_ENC,
      ST_CMD  = ST_CMD_ENC,
      ST_WR   = ST_WR_ENC,
      ST_RD   = ST_RD_ENC,
      ST_SKIP = ST_SKIP_ENC
   } state_e;

   // Auto-increment with wrap from the last implemented register back to 0.
   function automatic logic [ADDR_W-1:0] ptr_next(input logic [ADDR_W-1:0] ptr,
                                                   input logic [ADDR_W-1:0] last);
      logic [ADDR_W-1:0] nxt;
      if (ptr == last) begin
         nxt = '0;
      end else begin
         nxt = ptr + 7'd1;
      end
      return nxt;
   endfunction

endpackage

// File: rtl/spi_reg_bridge_if.sv
// Byte-level link between the SPI slave shift logic (master side) and the
// register bridge (slave side).
interface spi_reg_bridge_if;

   logic       frame_start;
   logic       frame_end;
   logic       rx_valid;
   logic [7:0] rx_data;
   logic [7:0] tx_data;
   logic       tx_load;

   modport master (
      output frame_start,
      output frame_end,
      output rx_valid,
      output rx_data,
      input  tx_data,
      input  tx_load
   );

   modport slave (
      input  frame_start,
      input  frame_end,
      input  rx_valid,
      input  rx_data,
      output tx_data,
      output tx_load
   );

endinterface

// File: rtl/spi_reg_file.sv
// NREGS x 8 register bank with one write port and one combinational read port;
// register 0 is a constant identification value.
module spi_reg_file
   import spi_reg_pkg::*;
#(
   parameter int         NREGS     = 16,
   parameter logic [7:0] ID_VALUE  = 8'hA5,
   parameter logic [7:0] RST_VALUE = 8'h00
) (
   input  logic              clk50m,
   input  logic              rst_n,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [7:0]        wdata,
   input  logic [ADDR_W-1:0] raddr,
   output logic [7:0]        rdata,
   output logic [NREGS*8-1:0] regs_flat
);

   logic [7:0] mem_q [NREGS];
   logic [7:0] mem_d [NREGS];

   // Next-state of the bank; writes to register 0 never take effect.
   always_comb begin
      for (int k = 0; k < NREGS; k++) begin
         if (k == 0) begin
            mem_d[k] = ID_VALUE;
         end else if (we && (waddr == ADDR_W'(k))) begin
            mem_d[k] = wdata;
         end else begin
            mem_d[k] = mem_q[k];
         end
      end
   end

   // Bank storage with synchronous active-low reset.
   always_ff @(posedge clk50m) begin
      if (!rst_n) begin
         for (int k = 0; k < NREGS; k++) begin
            mem_q[k] <= (k == 0) ? ID_VALUE : RST_VALUE;
         end
      end else begin
         for (int k = 0; k < NREGS; k++) begin
            mem_q[k] <= mem_d[k];
         end
      end
   end

   // AND-OR read mux; an unimplemented address reads as zero.
   always_comb begin
      rdata = 8'h00;
      for (int k = 0; k < NREGS; k++) begin
         rdata = rdata | ((raddr == ADDR_W'(k)) ? mem_q[k] : 8'h00);
      end
   end

   genvar g;
   generate
      for (g = 0; g < NREGS; g++) begin : g_flat
         assign regs_flat[8*g +: 8] = mem_q[g];
      end
   endgenerate

endmodule

// File: rtl/spi_reg_bridge.sv
// Frame decoder between the SPI slave receiver and a small register bank:
// command byte, then write data or dummy bytes that clock out read data.
module spi_reg_bridge
   import spi_reg_pkg::*;
#(
   parameter int         NREGS     = 16,
   parameter logic [7:0] ID_VALUE  = 8'hA5,
   parameter logic [7:0] RST_VALUE = 8'h00
) (
   input  logic               clk50m,
   input  logic               rst_n,
   spi_reg_bridge_if.slave    bus,
   input  logic               err_clr,
   output logic               busy,
   output logic               err_sticky,
   output logic [NREGS*8-1:0] regs_flat
);

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NREGS - 1);
   localparam logic [ADDR_W:0]   NREGS_L   = (ADDR_W + 1)'(NREGS);

   state_e            state_q, state_d, nxt_state;
   logic [ADDR_W-1:0] ptr_q, ptr_d;
   logic [7:0]        tx_data_q, tx_data_d;
   logic              tx_load_q, tx_load_d;
   logic              busy_q, busy_d;
   logic              err_q, err_d;

   logic              byte_v;
   logic              set_err;
   logic [ADDR_W-1:0] cmd_addr;
   logic [ADDR_W-1:0] ptr_inc;
   logic              we;
   logic [ADDR_W-1:0] waddr;
   logic [7:0]        wdata;
   logic [ADDR_W-1:0] raddr;
   logic [7:0]        rdata;

   spi_reg_file #(
      .NREGS     (NREGS),
      .ID_VALUE  (ID_VALUE),
      .RST_VALUE (RST_VALUE)
   ) u_file (
      .clk50m    (clk50m),
      .rst_n     (rst_n),
      .we        (we),
      .waddr     (waddr),
      .wdata     (wdata),
      .raddr     (raddr),
      .rdata     (rdata),
      .regs_flat (regs_flat)
   );

   // Frame decode: byte handling first, then frame_start / frame_end override the state.
   always_comb begin
      nxt_state = state_q;
      ptr_d     = ptr_q;
      tx_data_d = tx_data_q;
      tx_load_d = 1'b0;
      set_err   = 1'b0;
      we        = 1'b0;
      waddr     = ptr_q;
      wdata     = bus.rx_data;
      raddr     = ptr_q;
      cmd_addr  = bus.rx_data[ADDR_MSB:0];
      ptr_inc   = ptr_next(ptr_q, LAST_ADDR);
      // A byte arriving together with frame_start belongs to no frame.
      byte_v    = bus.rx_valid && !bus.frame_start;

      case (state_q)
         ST_CMD: begin
            if (byte_v) begin
               ptr_d = cmd_addr;
               if ({1'b0, cmd_addr} >= NREGS_L) begin
                  nxt_state = ST_SKIP;
                  set_err   = 1'b1;
               end else if (bus.rx_data[CMD_RW_BIT]) begin
                  nxt_state = ST_WR;
               end else begin
                  nxt_state = ST_RD;
                  raddr     = cmd_addr;
                  tx_data_d = rdata;
                  tx_load_d = 1'b1;
               end
            end else begin
               nxt_state = ST_CMD;
            end
         end
         ST_WR: begin
            if (byte_v) begin
               we    = 1'b1;
               ptr_d = ptr_inc;
            end else begin
               ptr_d = ptr_q;
            end
         end
         ST_RD: begin
            if (byte_v) begin
               ptr_d     = ptr_inc;
               raddr     = ptr_inc;
               tx_data_d = rdata;
               tx_load_d = 1'b1;
            end else begin
               ptr_d = ptr_q;
            end
         end
         ST_IDLE: nxt_state = ST_IDLE;
         ST_SKIP: nxt_state = ST_SKIP;
         default: nxt_state = ST_IDLE;
      endcase

      if (bus.frame_start) begin
         state_d = ST_CMD;
         ptr_d   = '0;
      end else if (bus.frame_end) begin
         state_d = ST_IDLE;
      end else begin
         state_d = nxt_state;
      end

      if (set_err) begin
         err_d = 1'b1;
      end else if (err_clr) begin
         err_d = 1'b0;
      end else begin
         err_d = err_q;
      end

      busy_d = (state_d != ST_IDLE);
   end

   // State, pointer and output registers with synchronous active-low reset.
   always_ff @(posedge clk50m) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         ptr_q     <= '0;
         tx_data_q <= 8'h00;
         tx_load_q <= 1'b0;
         busy_q    <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         tx_data_q <= tx_data_d;
         tx_load_q <= tx_load_d;
         busy_q    <= busy_d;
         err_q     <= err_d;
      end
   end

   assign bus.tx_data = tx_data_q;
   assign bus.tx_load = tx_load_q;
   assign busy        = busy_q;
   assign err_sticky  = err_q;

endmodule

// File: tb/tb_spi_reg_bridge.sv
// Directed bench for spi_reg_bridge: write/read frames, bad address, wrap,
// read-only register 0 and coincident frame events.
module tb_spi_reg_bridge;

   logic clk50m = 1'b0;
   always #10 clk50m = ~clk50m;

   logic         rst_n;
   logic         err_clr;
   logic         busy;
   logic         err_sticky;
   logic [127:0] regs_flat;

   spi_reg_bridge_if bus();

   spi_reg_bridge #(
      .NREGS     (16),
      .ID_VALUE  (8'hA5),
      .RST_VALUE (8'h00)
   ) dut (
      .clk50m     (clk50m),
      .rst_n      (rst_n),
      .bus        (bus),
      .err_clr    (err_clr),
      .busy       (busy),
      .err_sticky (err_sticky),
      .regs_flat  (regs_flat)
   );

   int         checks = 0;
   int         errors = 0;
   logic [7:0] exp_regs [16];

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [127:0] exp_flat();
      logic [127:0] f;
      for (int k = 0; k < 16; k++) f[8*k +: 8] = exp_regs[k];
      return f;
   endfunction

   task automatic cyc();
      @(posedge clk50m);
      #1;
   endtask

   task automatic send(input logic [7:0] b);
      cyc();
      bus.rx_data  = b;
      bus.rx_valid = 1'b1;
      cyc();
      bus.rx_valid = 1'b0;
   endtask

   task automatic start_f();
      bus.frame_start = 1'b1;
      cyc();
      bus.frame_start = 1'b0;
   endtask

   task automatic end_f();
      bus.frame_end = 1'b1;
      cyc();
      bus.frame_end = 1'b0;
   endtask

   task automatic reset_model();
      for (int k = 0; k < 16; k++) exp_regs[k] = 8'h00;
      exp_regs[0] = 8'hA5;
   endtask

   initial begin
      rst_n = 1'b0;
      err_clr = 1'b0;
      bus.frame_start = 1'b0;
      bus.frame_end   = 1'b0;
      bus.rx_valid    = 1'b0;
      bus.rx_data     = 8'h00;
      reset_model();
      repeat (3) cyc();
      rst_n = 1'b1;
      cyc();

      chk("rst_tx_data", bus.tx_data, 8'h00);
      chk("rst_tx_load", bus.tx_load, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_err", err_sticky, 1'b0);
      chk("rst_regs", regs_flat, exp_flat());

      // write frame: reg3=0x10, reg4=0x20
      start_f();
      chk("wr_busy_on", busy, 1'b1);
      send(8'h83);
      chk("wr_cmd_no_load", bus.tx_load, 1'b0);
      send(8'h10);
      exp_regs[3] = 8'h10;
      chk("wr_reg3", regs_flat[31:24], 8'h10);
      send(8'h20);
      exp_regs[4] = 8'h20;
      chk("wr_reg4", regs_flat[39:32], 8'h20);
      end_f();
      chk("wr_busy_off", busy, 1'b0);
      chk("wr_regs", regs_flat, exp_flat());

      // read frame from address 3
      start_f();
      send(8'h03);
      chk("rd0_load", bus.tx_load, 1'b1);
      chk("rd0_data", bus.tx_data, 8'h10);
      cyc();
      chk("rd0_load_drop", bus.tx_load, 1'b0);
      chk("rd0_data_hold", bus.tx_data, 8'h10);
      send(8'h00);
      chk("rd1_load", bus.tx_load, 1'b1);
      chk("rd1_data", bus.tx_data, 8'h20);
      send(8'h00);
      chk("rd2_load", bus.tx_load, 1'b1);
      chk("rd2_data", bus.tx_data, 8'h00);
      end_f();

      // bad address 0x35
      start_f();
      send(8'hB5);
      chk("bad_err", err_sticky, 1'b1);
      chk("bad_no_load", bus.tx_load, 1'b0);
      send(8'h10);
      chk("bad_skip_no_load", bus.tx_load, 1'b0);
      chk("bad_regs", regs_flat, exp_flat());
      end_f();
      chk("bad_err_held", err_sticky, 1'b1);
      err_clr = 1'b1;
      cyc();
      err_clr = 1'b0;
      chk("bad_err_clr", err_sticky, 1'b0);

      // clear and new error in the same cycle: set wins
      start_f();
      err_clr = 1'b1;
      send(8'hFF);
      chk("err_set_wins", err_sticky, 1'b1);
      err_clr = 1'b0;
      end_f();
      err_clr = 1'b1;
      cyc();
      err_clr = 1'b0;
      chk("err_clr2", err_sticky, 1'b0);

      // wrap write: reg15=0x11, reg0 read-only
      start_f();
      send(8'h8F);
      send(8'h11);
      exp_regs[15] = 8'h11;
      chk("wrap_reg15", regs_flat[127:120], 8'h11);
      send(8'h22);
      chk("wrap_reg0_ro", regs_flat[7:0], 8'hA5);
      end_f();
      chk("wrap_regs", regs_flat, exp_flat());

      // wrap read: 0x11 then 0xA5
      start_f();
      send(8'h0F);
      chk("wrap_rd15", bus.tx_data, 8'h11);
      send(8'h00);
      chk("wrap_rd0", bus.tx_data, 8'hA5);
      chk("wrap_rd0_load", bus.tx_load, 1'b1);
      end_f();

      // rx_valid coincident with frame_end is written
      start_f();
      send(8'h86);
      cyc();
      bus.rx_data   = 8'h66;
      bus.rx_valid  = 1'b1;
      bus.frame_end = 1'b1;
      cyc();
      bus.rx_valid  = 1'b0;
      bus.frame_end = 1'b0;
      exp_regs[6] = 8'h66;
      chk("end_coinc_reg6", regs_flat[55:48], 8'h66);
      chk("end_coinc_busy", busy, 1'b0);

      // bytes with no frame are ignored
      send(8'h87);
      send(8'h77);
      chk("noframe_busy", busy, 1'b0);
      chk("noframe_load", bus.tx_load, 1'b0);
      chk("noframe_regs", regs_flat, exp_flat());

      // frame_start mid-write restarts; coincident byte dropped
      start_f();
      send(8'h88);
      send(8'h01);
      exp_regs[8] = 8'h01;
      cyc();
      bus.frame_start = 1'b1;
      bus.rx_valid    = 1'b1;
      bus.rx_data     = 8'h44;
      cyc();
      bus.frame_start = 1'b0;
      bus.rx_valid    = 1'b0;
      chk("restart_busy", busy, 1'b1);
      chk("restart_drop", regs_flat, exp_flat());
      send(8'h8A);
      send(8'h55);
      exp_regs[10] = 8'h55;
      end_f();
      chk("restart_regs", regs_flat, exp_flat());

      // restart out of SKIP, then reset mid-read
      start_f();
      send(8'hF0);
      chk("skip_err", err_sticky, 1'b1);
      start_f();
      send(8'h0A);
      chk("skip_restart_rd", bus.tx_data, 8'h55);
      chk("skip_restart_load", bus.tx_load, 1'b1);
      rst_n = 1'b0;
      cyc();
      reset_model();
      chk("midrst_tx_data", bus.tx_data, 8'h00);
      chk("midrst_tx_load", bus.tx_load, 1'b0);
      chk("midrst_busy", busy, 1'b0);
      chk("midrst_err", err_sticky, 1'b0);
      chk("midrst_regs", regs_flat, exp_flat());
      rst_n = 1'b1;
      cyc();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
